nn_mem_ctrl: RTL and testbench

Load/compute sequencer and port owner for the NN memory system (weight banks plus input bank, 1-bit data).
- It accepts a serial bit stream with a valid/ready handshake and writes it in fixed order: weight banks 0..3, then input bank 0.
- It then hands both memory ports to the compute module until a new load is started.
- It replaces the bench-level load/compute multiplexing in front of `mem_sys`.

---
 rtl/nn_mem_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_nn_mem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mem_ctrl.sv
// Load/compute sequencer: streams bits into weight banks then input bank 0, then hands both ports to compute.
// Optional feature: define NN_MEM_CTRL_PARITY_EN to build the running XOR (load_parity) of each load.
module nn_mem_ctrl #(
   parameter int W_ADDR_LEN = 20,
   parameter int X_ADDR_LEN = 10,
   parameter int W_SEL_LEN  = 2,
   parameter int X_SEL_LEN  = 2,
   parameter int W_DEPTH    = 10,
   parameter int X_DEPTH    = 8,
   parameter int N_W_BANKS  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic                  in_data,
   output logic                  in_ready,
   output logic                  load_done,
   output logic                  busy,
   input  logic                  cmp_req,
   output logic                  cmp_gnt,
   input  logic [W_ADDR_LEN-1:0] cmp_w_addr,
   input  logic [W_SEL_LEN-1:0]  cmp_w_sel,
   input  logic                  cmp_w_we,
   input  logic [X_ADDR_LEN-1:0] cmp_x_addr,
   input  logic [X_SEL_LEN-1:0]  cmp_x_sel,
   input  logic                  cmp_x_we,
   input  logic                  cmp_data_in,
   output logic [W_ADDR_LEN-1:0] mem_w_addr,
   output logic [W_SEL_LEN-1:0]  mem_w_sel,
   output logic                  mem_w_we,
   output logic [X_ADDR_LEN-1:0] mem_x_addr,
   output logic [X_SEL_LEN-1:0]  mem_x_sel,
   output logic                  mem_x_we,
   output logic                  mem_data_in,
   output logic                  load_parity,
   output logic [2:0]            dbg_state
);

   localparam int CNT_W = (W_ADDR_LEN > X_ADDR_LEN) ? W_ADDR_LEN : X_ADDR_LEN;

   // Stream handshake: a beat is in_valid & in_ready at a rising edge; in_ready depends
   // only on the state, never on in_valid, and in_valid may drop between beats.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_LOAD_X = 3'd2,
      S_FLUSH  = 3'd3,
      S_READY  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      addr_cnt_q, addr_cnt_d;
   logic [W_SEL_LEN-1:0]  bank_cnt_q, bank_cnt_d;
   logic [W_ADDR_LEN-1:0] ld_w_addr_q, ld_w_addr_d;
   logic [W_SEL_LEN-1:0]  ld_w_sel_q, ld_w_sel_d;
   logic                  ld_w_we_q, ld_w_we_d;
   logic [X_ADDR_LEN-1:0] ld_x_addr_q, ld_x_addr_d;
   logic [X_SEL_LEN-1:0]  ld_x_sel_q, ld_x_sel_d;
   logic                  ld_x_we_q, ld_x_we_d;
   logic                  ld_data_q, ld_data_d;
   logic                  load_done_q, load_done_d;
   logic                  start_load;
   logic                  beat;

   assign in_ready  = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
   assign busy      = in_ready || (state_q == S_FLUSH);
   assign cmp_gnt   = (state_q == S_READY);
   assign load_done = load_done_q;
   assign dbg_state = state_q;
   assign beat      = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      addr_cnt_d  = addr_cnt_q;
      bank_cnt_d  = bank_cnt_q;
      ld_w_addr_d = ld_w_addr_q;
      ld_w_sel_d  = ld_w_sel_q;
      ld_w_we_d   = 1'b0;
      ld_x_addr_d = ld_x_addr_q;
      ld_x_sel_d  = ld_x_sel_q;
      ld_x_we_d   = 1'b0;
      ld_data_d   = ld_data_q;
      load_done_d = 1'b0;
      start_load  = 1'b0;
      case (state_q)
         S_IDLE:  start_load = start;
         S_READY: start_load = start & ~cmp_req;
         S_LOAD_W: begin
            if (beat) begin
               ld_w_we_d   = 1'b1;
               ld_w_addr_d = addr_cnt_q[W_ADDR_LEN-1:0];
               ld_w_sel_d  = bank_cnt_q;
               ld_data_d   = in_data;
               if (addr_cnt_q == CNT_W'(W_DEPTH - 1)) begin
                  addr_cnt_d = '0;
                  bank_cnt_d = bank_cnt_q + 1'b1;
                  if (bank_cnt_q == W_SEL_LEN'(N_W_BANKS - 1)) begin
                     state_d = S_LOAD_X;
                  end
               end else begin
                  addr_cnt_d = addr_cnt_q + 1'b1;
               end
            end
         end
         S_LOAD_X: begin
            if (beat) begin
               ld_x_we_d   = 1'b1;
               ld_x_addr_d = addr_cnt_q[X_ADDR_LEN-1:0];
               ld_x_sel_d  = '0;
               ld_data_d   = in_data;
               if (addr_cnt_q == CNT_W'(X_DEPTH - 1)) begin
                  addr_cnt_d = '0;
                  state_d    = S_FLUSH;
               end else begin
                  addr_cnt_d = addr_cnt_q + 1'b1;
               end
            end
         end
         S_FLUSH: begin
            // The last input-bank write is visible on the port during this cycle.
            state_d     = S_READY;
            load_done_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (start_load) begin
         state_d    = S_LOAD_W;
         addr_cnt_d = '0;
         bank_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_cnt_q  <= '0;
         bank_cnt_q  <= '0;
         ld_w_addr_q <= '0;
         ld_w_sel_q  <= '0;
         ld_w_we_q   <= 1'b0;
         ld_x_addr_q <= '0;
         ld_x_sel_q  <= '0;
         ld_x_we_q   <= 1'b0;
         ld_data_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_cnt_q  <= addr_cnt_d;
         bank_cnt_q  <= bank_cnt_d;
         ld_w_addr_q <= ld_w_addr_d;
         ld_w_sel_q  <= ld_w_sel_d;
         ld_w_we_q   <= ld_w_we_d;
         ld_x_addr_q <= ld_x_addr_d;
         ld_x_sel_q  <= ld_x_sel_d;
         ld_x_we_q   <= ld_x_we_d;
         ld_data_q   <= ld_data_d;
         load_done_q <= load_done_d;
      end
   end

   // Compute owns the memory ports combinationally only while READY.
   always_comb begin
      if (cmp_gnt) begin
         mem_w_addr  = cmp_w_addr;
         mem_w_sel   = cmp_w_sel;
         mem_w_we    = cmp_w_we;
         mem_x_addr  = cmp_x_addr;
         mem_x_sel   = cmp_x_sel;
         mem_x_we    = cmp_x_we;
         mem_data_in = cmp_data_in;
      end else begin
         mem_w_addr  = ld_w_addr_q;
         mem_w_sel   = ld_w_sel_q;
         mem_w_we    = ld_w_we_q;
         mem_x_addr  = ld_x_addr_q;
         mem_x_sel   = ld_x_sel_q;
         mem_x_we    = ld_x_we_q;
         mem_data_in = ld_data_q;
      end
   end

`ifdef NN_MEM_CTRL_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (start_load) begin
         parity_d = 1'b0;
      end else if (beat) begin
         parity_d = parity_q ^ in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign load_parity = parity_q;
`else
   assign load_parity = 1'b0;
`endif

endmodule

// File: tb/tb_nn_mem_ctrl.sv
// Directed self-checking bench for nn_mem_ctrl: load order, timing, port handover, restart and parity.
module tb_nn_mem_ctrl;

  localparam int W = 24;       // {is_x, sel[1:0], addr[19:0], data}
  localparam int N_BEATS = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_data = 1'b0;
  logic        in_ready, load_done, busy, cmp_gnt, load_parity;
  logic        cmp_req = 1'b0;
  logic [19:0] cmp_w_addr = '0;
  logic [1:0]  cmp_w_sel = '0;
  logic        cmp_w_we = 1'b0;
  logic [9:0]  cmp_x_addr = '0;
  logic [1:0]  cmp_x_sel = '0;
  logic        cmp_x_we = 1'b0;
  logic        cmp_data_in = 1'b0;
  logic [19:0] mem_w_addr;
  logic [1:0]  mem_w_sel;
  logic        mem_w_we;
  logic [9:0]  mem_x_addr;
  logic [1:0]  mem_x_sel;
  logic        mem_x_we;
  logic        mem_data_in;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  nn_mem_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_done(load_done), .busy(busy),
    .cmp_req(cmp_req), .cmp_gnt(cmp_gnt),
    .cmp_w_addr(cmp_w_addr), .cmp_w_sel(cmp_w_sel), .cmp_w_we(cmp_w_we),
    .cmp_x_addr(cmp_x_addr), .cmp_x_sel(cmp_x_sel), .cmp_x_we(cmp_x_we),
    .cmp_data_in(cmp_data_in),
    .mem_w_addr(mem_w_addr), .mem_w_sel(mem_w_sel), .mem_w_we(mem_w_we),
    .mem_x_addr(mem_x_addr), .mem_x_sel(mem_x_sel), .mem_x_we(mem_x_we),
    .mem_data_in(mem_data_in), .load_parity(load_parity), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // loader-side write monitor and load_done pulse tracker
  always @(negedge clk) begin
    if (rst && !cmp_gnt) begin
      if (mem_w_we) obs_q.push_back({1'b0, mem_w_sel, mem_w_addr, mem_data_in});
      if (mem_x_we) obs_q.push_back({1'b1, mem_x_sel, 10'd0, mem_x_addr, mem_data_in});
    end
    if (load_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // expected write order: banks 0..3 addr 0..9, then input bank 0 addr 0..7
  function automatic void build_expected(input logic [N_BEATS-1:0] bits);
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back({1'b0, 2'(i / 10), 20'(i % 10), bits[i]});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 2'd0, 20'(i), bits[40 + i]});
  endfunction

  task automatic drive_load(input logic [N_BEATS-1:0] bits, input int gap, output bit timed_out);
    int done_before;
    done_before = done_cnt;
    @(negedge clk);
    start = 1'b1;
    cmp_req = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N_BEATS; i++) begin
      in_valid = 1'b1;
      in_data = bits[i];
      @(negedge clk);
      if (i == 0) first_cyc = cyc;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (done_cnt != done_before) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, load_done, busy, cmp_gnt, load_parity} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got %b exp 00000", {in_ready, load_done, busy, cmp_gnt, load_parity});
    end
    checks++;
    if ({mem_w_we, mem_x_we, mem_data_in} !== 3'b0 || mem_w_addr !== '0 || mem_x_addr !== '0 ||
        mem_w_sel !== '0 || mem_x_sel !== '0) begin
      failures++;
      $display("FAIL reset_mem got we=%b%b waddr=%h xaddr=%h exp all zero", mem_w_we, mem_x_we, mem_w_addr, mem_x_addr);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got %0d exp 0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // shared sequence/timing comparison body is repeated inline per test
  task automatic test_load_contiguous();
    logic [N_BEATS-1:0] bits;
    bit to;
    for (int i = 0; i < N_BEATS; i++) bits[i] = (i < 40) ? 1'((i % 10) & 1) : 1'((i - 40) & 1);
    build_expected(bits);
    obs_q.delete();
    done_cnt = 0;
    drive_load(bits, 0, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL contig_done_timeout got no load_done exp pulse");
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL contig_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL contig_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL contig_done_pulses got %0d exp 1", done_cnt);
    end
    // 48 beat cycles + 1 flush cycle, counted from the first beat cycle
    checks++;
    if (done_cyc - first_cyc + 1 != 49) begin
      failures++;
      $display("FAIL contig_latency got %0d exp 49", done_cyc - first_cyc + 1);
    end
    checks++;
    if (cmp_gnt !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL contig_ready got gnt=%b busy=%b rdy=%b exp 1 0 0", cmp_gnt, busy, in_ready);
    end
  endtask

  task automatic test_cmp_passthrough();
    @(negedge clk);
    cmp_w_addr = 20'd5;
    cmp_w_sel = 2'd2;
    cmp_w_we = 1'b1;
    cmp_x_addr = 10'd3;
    cmp_x_sel = 2'd1;
    cmp_x_we = 1'b1;
    cmp_data_in = 1'b1;
    #1;
    checks++;
    if (mem_w_addr !== 20'd5 || mem_w_sel !== 2'd2 || mem_w_we !== 1'b1) begin
      failures++;
      $display("FAIL pass_w got addr=%0d sel=%0d we=%b exp 5 2 1", mem_w_addr, mem_w_sel, mem_w_we);
    end
    checks++;
    if (mem_x_addr !== 10'd3 || mem_x_sel !== 2'd1 || mem_x_we !== 1'b1 || mem_data_in !== 1'b1) begin
      failures++;
      $display("FAIL pass_x got addr=%0d sel=%0d we=%b d=%b exp 3 1 1 1", mem_x_addr, mem_x_sel, mem_x_we, mem_data_in);
    end
    cmp_x_we = 1'b0;
    cmp_data_in = 1'b0;
  endtask

  task automatic test_start_in_ready();
    @(negedge clk);
    cmp_req = 1'b1;
    start = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cmp_gnt !== 1'b1 || dbg_state !== 3'd4) begin
      failures++;
      $display("FAIL start_ignored got gnt=%b state=%0d exp 1 4", cmp_gnt, dbg_state);
    end
    cmp_req = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (cmp_gnt !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_taken got gnt=%b rdy=%b busy=%b exp 0 1 1", cmp_gnt, in_ready, busy);
    end
    // compute inputs still 5/2/1; loader regs keep the last write (bank 3, addr 9)
    checks++;
    if (mem_w_addr !== 20'd9 || mem_w_sel !== 2'd3 || mem_w_we !== 1'b0) begin
      failures++;
      $display("FAIL loadw_isolated got addr=%0d sel=%0d we=%b exp 9 3 0", mem_w_addr, mem_w_sel, mem_w_we);
    end
    cmp_w_addr = '0;
    cmp_w_sel = '0;
    cmp_w_we = 1'b0;
    cmp_x_addr = '0;
    cmp_x_sel = '0;
  endtask

  task automatic test_reset_mid_load();
    logic [N_BEATS-1:0] bits;
    bit to;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (mem_w_we !== 1'b1 || mem_w_sel !== 2'd1 || mem_w_addr !== 20'd9) begin
      failures++;
      $display("FAIL beat20_write got we=%b sel=%0d addr=%0d exp 1 1 9", mem_w_we, mem_w_sel, mem_w_addr);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_w_we !== 1'b0 || mem_x_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || mem_w_addr !== '0) begin
      failures++;
      $display("FAIL async_reset got we=%b%b busy=%b rdy=%b addr=%0d exp 0 0 0 0 0", mem_w_we, mem_x_we, busy, in_ready, mem_w_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N_BEATS; i++) bits[i] = 1'((i >> 1) & 1);
    build_expected(bits);
    obs_q.delete();
    done_cnt = 0;
    drive_load(bits, 0, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL restart_done_timeout got no load_done exp pulse");
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL restart_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL restart_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [N_BEATS-1:0] bits;
    bit to;
    for (int i = 0; i < N_BEATS; i++) bits[i] = (i < 40) ? 1'((i % 10) & 1) : 1'((i - 40) & 1);
    build_expected(bits);
    obs_q.delete();
    done_cnt = 0;
    drive_load(bits, 1, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL gap_done_timeout got no load_done exp pulse");
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL gap_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL gap_write[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL gap_done_pulses got %0d exp 1", done_cnt);
    end
    // 48 beat cycles + 47 idle cycles + 1 flush cycle
    checks++;
    if (done_cyc - first_cyc + 1 != 96) begin
      failures++;
      $display("FAIL gap_latency got %0d exp 96", done_cyc - first_cyc + 1);
    end
  endtask

  task automatic test_parity();
    logic [N_BEATS-1:0] bits;
    logic exp_par;
    bit to;
    for (int pass = 0; pass < 2; pass++) begin
      bits = '0;
      // 13 ones on the first load, 12 on the second, spread across both banks
      for (int i = 0; i < 13 - pass; i++) bits[(i * 7) % N_BEATS] = 1'b1;
`ifdef NN_MEM_CTRL_PARITY_EN
      exp_par = (pass == 0) ? 1'b1 : 1'b0;
`else
      exp_par = 1'b0;
`endif
      drive_load(bits, 0, to);
      checks++;
      if (to) begin
        failures++;
        $display("FAIL parity_done_timeout[%0d] got no load_done exp pulse", pass);
      end
      @(negedge clk);
      #1;
      checks++;
      if (load_parity !== exp_par) begin
        failures++;
        $display("FAIL parity[%0d] got %b exp %b", pass, load_parity, exp_par);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_contiguous();
    test_cmp_passthrough();
    test_start_in_ready();
    test_reset_mid_load();
    test_gaps();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
